pix_capture: RTL and testbench
==============================

// Module: pix_capture
// PURPOSE
//   Pixel-domain capture stage fed by the sensor pixel clock MMCM (clk_pix, pll_locked).
//   - Samples image-sensor frame-valid, line-valid and pixel data.
//   - Aligns capture to frame boundaries and packs pixels into words for the frame-buffer write FIFO.
//   - Reports per-frame line/pixel counts and overflow status to the host.
// PARAMETERS
//   PIX_WIDTH     8   bits per sensor pixel
//   PIX_PER_WORD  4   pixels packed per FIFO word; FIFO width W = PIX_WIDTH*PIX_PER_WORD
//   LINE_CNT_W    12  width of line counter
//   PIX_CNT_W     12  width of pixel-per-line counter
// PORTS
//   clk_pix      in   1           pixel clock (MMCM output); only clock
//   reset_n      in   1           reset, synchronous, active-low
//   pll_locked   in   1           MMCM lock; async to logic, 2-flop synchronised internally
//   capture_en   in   1           host arm request (level, already in clk_pix domain)
//   pix_fv       in   1           sensor frame valid
//   pix_lv       in   1           sensor line valid
//   pix_data     in   PIX_WIDTH   sensor pixel data
//   fifo_full    in   1           write FIFO full
//   fifo_wr_en   out  1           write strobe, one cycle per word
//   fifo_din     out  W           packed word; first pixel of word in LSBs
//   busy         out  1           high in any state other than IDLE
//   frame_done   out  1           one-cycle pulse at end of a complete frame
//   overflow     out  1           sticky: a word was dropped on fifo_full
//   line_count   out  LINE_CNT_W  lines captured in current/last frame
//   pix_count    out  PIX_CNT_W   pixels in last completed line
// BEHAVIOUR
//   - Reset (reset_n=0 at clk_pix edge): all outputs 0, state IDLE, pack register and counters cleared.
//   - Input stage: pix_fv/pix_lv/pix_data registered once (fv_r, lv_r, d_r); all decisions use registered values.
//   - locked_s = pll_locked after 2-flop synchroniser.
//   - FSM:
//     - IDLE: capture_en & locked_s -> WAIT_FV_LOW; on that transition clear overflow, line_count.
//     - WAIT_FV_LOW: fv_r=0 -> WAIT_FV_HIGH (never start mid-frame).
//     - WAIT_FV_HIGH: fv_r=1 -> CAPTURE.
//     - CAPTURE: fv_r falling -> FLUSH.
//     - FLUSH: one cycle; pulses frame_done; -> IDLE (re-arms next cycle if capture_en still 1).
//   - Packing (CAPTURE, fv_r&lv_r): d_r written into slot idx; idx increments, wraps at PIX_PER_WORD-1.
//     - Full word: fifo_wr_en asserts the cycle after the completing pixel is in d_r (2 clk_pix after pins).
//   - Line end (lv_r 1->0):
//     - if idx!=0, remaining slots zero-padded and word written next cycle; idx <- 0;
//     - line_count += 1, saturating at all-ones;
//     - pix_count <- pixels in that line, saturating.
//   - Line end coincident with word completion: single write, no padding word.
//   - fv_r falls while lv_r=1: treated as line end, then FLUSH.
//   - fifo_full: when a write is due and fifo_full=1, fifo_wr_en stays 0, word is dropped,
//     overflow <- 1 (held until next arm).
//   - fifo_wr_en is never asserted while fifo_full=1.
//   - capture_en deasserted in CAPTURE: current frame completes normally, then IDLE.
//   - locked_s=0 in any non-IDLE state: -> IDLE next cycle; partial word discarded;
//     no frame_done; counts hold.
//   - frame_done and fifo_wr_en (padding word) may assert in the same cycle.
// CONFIGURATION
//   PIX_CAPTURE_TESTPAT_EN defined:
//     - d_r replaced by low PIX_WIDTH bits of the pixel index within the current line (0,1,2..);
//     - fv/lv timing still taken from the sensor.
//   Undefined: sensor pix_data captured (default build).
// TESTING
//   1 reset_n=0 for 3 cycles, fv/lv toggling -> all outputs 0, busy=0, no fifo_wr_en.
//   2 arm with fv=1 mid-frame; next frame 2 lines x 8 px, data 0x01..0x10 ->
//     writes 0x04030201,0x08070605,0x0C0B0A09,0x100F0E0D; line_count=2, pix_count=8, one frame_done.
//   3 one line of 6 px 0x01..0x06 -> writes 0x04030201, 0x00000605.
//   4 fifo_full=1 while 2nd word due -> only 1 write, overflow=1; stays 1 until capture_en re-arm.
//   5 pll_locked=0 mid-line -> busy=0 within 4 cycles, no frame_done, no further writes.
//   6 PIX_CAPTURE_TESTPAT_EN, 8-px line -> writes 0x03020100, 0x07060504.

Source files
------------

// File: rtl/pix_capture.sv
// Sensor pixel capture: frame-aligned packing of pixels into FIFO words.
// Optional PIX_CAPTURE_TESTPAT_EN replaces pixel data with the in-line pixel index.
module pix_capture #(
    parameter int PIX_WIDTH    = 8,
    parameter int PIX_PER_WORD = 4,
    parameter int LINE_CNT_W   = 12,
    parameter int PIX_CNT_W    = 12
) (
    input  logic                              clk_pix,
    input  logic                              reset_n,
    input  logic                              pll_locked,
    input  logic                              capture_en,
    input  logic                              pix_fv,
    input  logic                              pix_lv,
    input  logic [PIX_WIDTH-1:0]              pix_data,
    input  logic                              fifo_full,
    output logic                              fifo_wr_en,
    output logic [PIX_WIDTH*PIX_PER_WORD-1:0] fifo_din,
    output logic                              busy,
    output logic                              frame_done,
    output logic                              overflow,
    output logic [LINE_CNT_W-1:0]             line_count,
    output logic [PIX_CNT_W-1:0]              pix_count
);

    localparam int W     = PIX_WIDTH * PIX_PER_WORD;
    localparam int IDX_W = (PIX_PER_WORD > 1) ? $clog2(PIX_PER_WORD) : 1;
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(PIX_PER_WORD - 1);

    typedef enum logic [2:0] {
        IDLE,
        WAIT_FV_LOW,
        WAIT_FV_HIGH,
        CAPTURE,
        FLUSH
    } state_t;

    state_t                 state;
    logic                   fv_r;
    logic                   lv_r;
    logic [PIX_WIDTH-1:0]   d_r;
    logic                   lk_meta;
    logic                   locked_s;
    logic [W-1:0]           pack;
    logic [W-1:0]           word_nxt;
    logic [W-1:0]           din_q;
    logic                   wr_q;
    logic [IDX_W-1:0]       idx;
    logic [PIX_CNT_W-1:0]   line_pix;
    logic                   act;
    logic                   act_q;

`ifdef PIX_CAPTURE_TESTPAT_EN
    logic [PIX_WIDTH-1:0]   tp_cnt;
    logic                   unused_pix;
    assign unused_pix = ^pix_data;

    // Register sensor strobes; data becomes the pixel index within the line.
    always_ff @(posedge clk_pix) begin
        if (!reset_n) begin
            fv_r   <= 1'b0;
            lv_r   <= 1'b0;
            d_r    <= '0;
            tp_cnt <= '0;
        end else begin
            fv_r <= pix_fv;
            lv_r <= pix_lv;
            d_r  <= tp_cnt;
            if (pix_fv & pix_lv) tp_cnt <= tp_cnt + PIX_WIDTH'(1);
            else                 tp_cnt <= '0;
        end
    end
`else
    // Register sensor strobes and pixel data once before any decision.
    always_ff @(posedge clk_pix) begin
        if (!reset_n) begin
            fv_r <= 1'b0;
            lv_r <= 1'b0;
            d_r  <= '0;
        end else begin
            fv_r <= pix_fv;
            lv_r <= pix_lv;
            d_r  <= pix_data;
        end
    end
`endif

    // Two-flop synchroniser for the MMCM lock indication.
    always_ff @(posedge clk_pix) begin
        if (!reset_n) begin
            lk_meta  <= 1'b0;
            locked_s <= 1'b0;
        end else begin
            lk_meta  <= pll_locked;
            locked_s <= lk_meta;
        end
    end

    // Current word with the registered pixel dropped into its slot.
    always_comb begin
        act      = fv_r & lv_r;
        word_nxt = pack;
        word_nxt[int'(idx)*PIX_WIDTH +: PIX_WIDTH] = d_r;
    end

    assign fifo_wr_en = wr_q & ~fifo_full;
    assign fifo_din   = din_q;

    // Capture FSM with packing, line accounting and overflow tracking.
    always_ff @(posedge clk_pix) begin
        if (!reset_n) begin
            state      <= IDLE;
            busy       <= 1'b0;
            frame_done <= 1'b0;
            overflow   <= 1'b0;
            line_count <= '0;
            pix_count  <= '0;
            wr_q       <= 1'b0;
            din_q      <= '0;
            pack       <= '0;
            idx        <= '0;
            line_pix   <= '0;
            act_q      <= 1'b0;
        end else begin
            frame_done <= 1'b0;
            wr_q       <= 1'b0;
            if (wr_q & fifo_full) overflow <= 1'b1;
            if (state != IDLE && !locked_s) begin
                state    <= IDLE;
                busy     <= 1'b0;
                pack     <= '0;
                idx      <= '0;
                line_pix <= '0;
                act_q    <= 1'b0;
            end else begin
                unique case (state)
                    IDLE: begin
                        if (capture_en && locked_s) begin
                            state      <= WAIT_FV_LOW;
                            busy       <= 1'b1;
                            overflow   <= 1'b0;
                            line_count <= '0;
                            pack       <= '0;
                            idx        <= '0;
                            line_pix   <= '0;
                            act_q      <= 1'b0;
                        end
                    end
                    WAIT_FV_LOW: begin
                        if (!fv_r) state <= WAIT_FV_HIGH;
                    end
                    WAIT_FV_HIGH: begin
                        if (fv_r) state <= CAPTURE;
                    end
                    CAPTURE: begin
                        act_q <= act;
                        if (act) begin
                            if (line_pix != '1)
                                line_pix <= line_pix + PIX_CNT_W'(1);
                            if (idx == IDX_LAST) begin
                                wr_q  <= 1'b1;
                                din_q <= word_nxt;
                                pack  <= '0;
                                idx   <= '0;
                            end else begin
                                pack <= word_nxt;
                                idx  <= idx + IDX_W'(1);
                            end
                        end else if (act_q) begin
                            if (idx != '0) begin
                                wr_q  <= 1'b1;
                                din_q <= pack;
                            end
                            pack      <= '0;
                            idx       <= '0;
                            line_pix  <= '0;
                            pix_count <= line_pix;
                            if (line_count != '1)
                                line_count <= line_count + LINE_CNT_W'(1);
                        end
                        if (!fv_r) begin
                            state      <= FLUSH;
                            frame_done <= 1'b1;
                        end
                    end
                    FLUSH: begin
                        state <= IDLE;
                        busy  <= 1'b0;
                        act_q <= 1'b0;
                    end
                    default: begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_pix_capture.sv
// Randomised self-checking bench for pix_capture.
// Expected words come from a per-line packing model.
module tb_pix_capture;

`ifdef PIX_CAPTURE_TESTPAT_EN
    localparam bit TP = 1'b1;
`else
    localparam bit TP = 1'b0;
`endif
    localparam logic [31:0] W0 = TP ? 32'h03020100 : 32'h04030201;

    logic        clk_pix = 1'b0;
    logic        reset_n;
    logic        pll_locked;
    logic        capture_en;
    logic        pix_fv;
    logic        pix_lv;
    logic [7:0]  pix_data;
    logic        fifo_full;
    logic        fifo_wr_en;
    logic [31:0] fifo_din;
    logic        busy;
    logic        frame_done;
    logic        overflow;
    logic [11:0] line_count;
    logic [11:0] pix_count;

    int n_err = 0;
    int n_chk = 0;
    int cyc = 0;
    int fd_cnt = 0;
    int bad_wr = 0;
    int lock_cyc = -1;
    int busy_low = -1;
    int seq = 1;
    int fd0;
    int exp_lines;
    int exp_pix;
    logic [31:0] got_q[$];
    logic [31:0] exp_q[$];

    always #5 clk_pix = ~clk_pix;

    pix_capture dut (
        .clk_pix    (clk_pix),
        .reset_n    (reset_n),
        .pll_locked (pll_locked),
        .capture_en (capture_en),
        .pix_fv     (pix_fv),
        .pix_lv     (pix_lv),
        .pix_data   (pix_data),
        .fifo_full  (fifo_full),
        .fifo_wr_en (fifo_wr_en),
        .fifo_din   (fifo_din),
        .busy       (busy),
        .frame_done (frame_done),
        .overflow   (overflow),
        .line_count (line_count),
        .pix_count  (pix_count)
    );

    always @(negedge clk_pix) begin
        cyc++;
        if (fifo_wr_en) got_q.push_back(fifo_din);
        if (frame_done) fd_cnt++;
        if (fifo_wr_en && fifo_full) bad_wr++;
        if (lock_cyc >= 0 && busy_low < 0 && !busy) busy_low = cyc;
    end

    task automatic chk(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_pix);
        #1;
    endtask

    task automatic model_line(input logic [7:0] q[$]);
        logic [31:0] w;
        for (int i = 0; i < q.size(); i += 4) begin
            w = '0;
            for (int j = 0; j < 4; j++)
                if (i + j < q.size()) w |= 32'(q[i+j]) << (8 * j);
            exp_q.push_back(w);
        end
    endtask

    task automatic check_words(input string tag);
        int n;
        chk({tag, "_nwords"}, 64'(got_q.size()), 64'(exp_q.size()));
        n = (got_q.size() < exp_q.size()) ? got_q.size() : exp_q.size();
        for (int i = 0; i < n; i++)
            chk($sformatf("%s_w%0d", tag, i), 64'(got_q[i]), 64'(exp_q[i]));
        got_q.delete();
        exp_q.delete();
    endtask

    task automatic send_frame(input int nlines, input int npix,
                              input bit seqd, input bit cut,
                              input int full_pix, input int lock_pix,
                              input bit use_model);
        logic [7:0] lq[$];
        logic [7:0] d;
        pix_fv = 1'b0;
        pix_lv = 1'b0;
        repeat (4) tick();
        pix_fv = 1'b1;
        repeat (3) tick();
        capture_en = 1'b0;
        exp_lines = nlines;
        exp_pix = npix;
        for (int l = 0; l < nlines; l++) begin
            lq.delete();
            for (int p = 0; p < npix; p++) begin
                if (l == 0 && p == full_pix) fifo_full = 1'b1;
                if (l == 0 && p == lock_pix) begin
                    pll_locked = 1'b0;
                    lock_cyc = cyc;
                end
                d = seqd ? 8'(seq) : 8'($urandom);
                seq++;
                if (TP) lq.push_back(8'(p));
                else    lq.push_back(d);
                pix_lv = 1'b1;
                pix_data = d;
                tick();
            end
            pix_lv = 1'b0;
            pix_data = 8'($urandom);
            if (cut && l == nlines - 1) pix_fv = 1'b0;
            if (use_model) model_line(lq);
            repeat (3) tick();
        end
        pix_fv = 1'b0;
        repeat (8) tick();
    endtask

    initial begin
        reset_n = 1'b0;
        pll_locked = 1'b1;
        capture_en = 1'b0;
        pix_fv = 1'b0;
        pix_lv = 1'b0;
        pix_data = '0;
        fifo_full = 1'b0;

        // reset with toggling sensor strobes
        for (int i = 0; i < 3; i++) begin
            pix_fv = 1'($urandom);
            pix_lv = 1'($urandom);
            pix_data = 8'($urandom);
            tick();
            chk("rst_wr", 64'(fifo_wr_en), 64'd0);
            chk("rst_busy", 64'(busy), 64'd0);
            chk("rst_fd", 64'(frame_done), 64'd0);
            chk("rst_ovf", 64'(overflow), 64'd0);
            chk("rst_lc", 64'(line_count), 64'd0);
            chk("rst_pc", 64'(pix_count), 64'd0);
            chk("rst_din", 64'(fifo_din), 64'd0);
        end
        reset_n = 1'b1;
        pix_fv = 1'b0;
        pix_lv = 1'b0;
        repeat (4) tick();
        chk("idle_busy", 64'(busy), 64'd0);
        chk("idle_nwr", 64'(got_q.size()), 64'd0);

        // arm in the middle of a frame, then capture 2 x 8
        fd0 = fd_cnt;
        pix_fv = 1'b1;
        capture_en = 1'b1;
        for (int i = 0; i < 6; i++) begin
            pix_lv = 1'(i & 1);
            pix_data = 8'($urandom);
            tick();
        end
        pix_lv = 1'b0;
        chk("arm_busy", 64'(busy), 64'd1);
        seq = 1;
        send_frame(2, 8, 1'b1, 1'b0, -1, -1, TP);
        if (!TP)
            exp_q = '{32'h04030201, 32'h08070605, 32'h0C0B0A09, 32'h100F0E0D};
        check_words("t2");
        chk("t2_fd", 64'(fd_cnt - fd0), 64'd1);
        chk("t2_lc", 64'(line_count), 64'd2);
        chk("t2_pc", 64'(pix_count), 64'd8);
        chk("t2_busy", 64'(busy), 64'd0);
        chk("t2_ovf", 64'(overflow), 64'd0);

        // 6-pixel line, frame ends together with the line
        fd0 = fd_cnt;
        capture_en = 1'b1;
        seq = 1;
        send_frame(1, 6, 1'b1, 1'b1, -1, -1, TP);
        if (!TP) exp_q = '{32'h04030201, 32'h00000605};
        check_words("t3");
        chk("t3_fd", 64'(fd_cnt - fd0), 64'd1);
        chk("t3_lc", 64'(line_count), 64'd1);
        chk("t3_pc", 64'(pix_count), 64'd6);

        // FIFO full while the second word is due
        fd0 = fd_cnt;
        capture_en = 1'b1;
        seq = 1;
        send_frame(1, 8, 1'b1, 1'b0, 6, -1, 1'b0);
        fifo_full = 1'b0;
        exp_q = '{W0};
        check_words("t4");
        chk("t4_fd", 64'(fd_cnt - fd0), 64'd1);
        chk("t4_ovf", 64'(overflow), 64'd1);
        repeat (5) tick();
        chk("t4_ovf_hold", 64'(overflow), 64'd1);
        capture_en = 1'b1;
        repeat (2) tick();
        chk("t4_ovf_clr", 64'(overflow), 64'd0);

        // MMCM lock lost mid-line
        fd0 = fd_cnt;
        seq = 1;
        send_frame(1, 8, 1'b1, 1'b0, -1, 5, 1'b0);
        exp_q = '{W0};
        check_words("t5");
        chk("t5_lat", 64'(busy_low >= 0 && busy_low - lock_cyc <= 4), 64'd1);
        chk("t5_fd", 64'(fd_cnt - fd0), 64'd0);
        chk("t5_lc", 64'(line_count), 64'd0);
        chk("t5_pc", 64'(pix_count), 64'd8);
        pll_locked = 1'b1;
        repeat (4) tick();

        // random frames against the packing model
        for (int k = 0; k < 8; k++) begin
            int nl;
            int np;
            bit ct;
            nl = int'($urandom_range(1, 4));
            np = int'($urandom_range(1, 20));
            ct = 1'($urandom_range(0, 1));
            fd0 = fd_cnt;
            capture_en = 1'b1;
            send_frame(nl, np, 1'b0, ct, -1, -1, 1'b1);
            check_words($sformatf("rnd%0d", k));
            chk("rnd_fd", 64'(fd_cnt - fd0), 64'd1);
            chk("rnd_lc", 64'(line_count), 64'(exp_lines));
            chk("rnd_pc", 64'(pix_count), 64'(exp_pix));
            chk("rnd_busy", 64'(busy), 64'd0);
        end

        chk("wr_while_full", 64'(bad_wr), 64'd0);
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
